// File: rtl/arf_rat_pkg.sv
// rtl/arf_rat_pkg.sv - shared types and source-resolve helper for the ARF/RAT block
package arf_rat_pkg;

    localparam int N_ARF          = 32;
    localparam int ROB_N_ENTRIES  = 16;
    localparam int REG_DATA_WIDTH = 32;
    localparam int ARF_ID_W       = $clog2(N_ARF);
    localparam int ROB_ID_W       = $clog2(ROB_N_ENTRIES);

    typedef logic [ARF_ID_W-1:0]       arf_id_t;
    typedef logic [ROB_ID_W-1:0]       rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        logic    busy;
        rob_id_t rob_id;
    } rat_entry_t;

    typedef struct packed {
        logic      renamed;
        rob_id_t   rob_id;
        reg_data_t data;
    } src_res_t;

    // A retiring producer that still owns the mapping is forwarded as committed data,
    // so the consumer never waits on a tag that is leaving the ROB.
    function automatic src_res_t resolve_src(
        input arf_id_t    id,
        input rat_entry_t ent,
        input reg_data_t  arf_data,
        input logic       ret,
        input arf_id_t    ret_arf_id,
        input rob_id_t    ret_rob_id,
        input reg_data_t  ret_data
    );
        src_res_t res;
        logic     byp;
        byp         = ret && (ret_arf_id == id) && ent.busy && (ent.rob_id == ret_rob_id);
        res.renamed = (id != '0) && ent.busy && !byp;
        res.rob_id  = ent.rob_id;
        if (id == '0)
            res.data = '0;
        else if (byp)
            res.data = ret_data;
        else
            res.data = arf_data;
        return res;
    endfunction

endpackage

// File: rtl/arf_regfile.sv
// rtl/arf_regfile.sv - 32x32 architectural register file, 1 write / 2 read ports, x0 reads zero
module arf_regfile
    import arf_rat_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_wr_en,
    input  arf_id_t   i_wr_addr,
    input  reg_data_t i_wr_data,
    input  arf_id_t   i_rd0_addr,
    output reg_data_t o_rd0_data,
    input  arf_id_t   i_rd1_addr,
    output reg_data_t o_rd1_data
);

    reg_data_t r_data [N_ARF];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ARF; i++)
                r_data[i] <= '0;
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_data[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd0_data = (i_rd0_addr == '0) ? '0 : r_data[i_rd0_addr];
    assign o_rd1_data = (i_rd1_addr == '0) ? '0 : r_data[i_rd1_addr];

endmodule

// File: rtl/arf_rat.sv
// rtl/arf_rat.sv - architectural register file plus register alias table at dispatch
module arf_rat
    import arf_rat_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      dispatch_fire,
    input  rob_id_t   dispatch_rob_id,
    input  logic      dispatch_dst_valid,
    input  arf_id_t   dispatch_dst_arf_id,
    input  arf_id_t   src1_arf_id,
    input  arf_id_t   src2_arf_id,
    output logic      src1_renamed,
    output rob_id_t   src1_rob_id,
    output reg_data_t src1_reg_data,
    output logic      src2_renamed,
    output rob_id_t   src2_rob_id,
    output reg_data_t src2_reg_data,
    input  logic      retire,
    input  rob_id_t   retire_rob_id,
    input  arf_id_t   retire_arf_id,
    input  reg_data_t retire_reg_data,
    input  logic      flush
);

    rat_entry_t r_rat [N_ARF];

    logic      w_ret_we;
    logic      w_disp_we;
    reg_data_t w_rf_rd0;
    reg_data_t w_rf_rd1;
    src_res_t  w_src1;
    src_res_t  w_src2;

    assign w_ret_we  = retire && (retire_arf_id != '0);
    assign w_disp_we = dispatch_fire && dispatch_dst_valid && (dispatch_dst_arf_id != '0);

    arf_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_ret_we),
        .i_wr_addr  (retire_arf_id),
        .i_wr_data  (retire_reg_data),
        .i_rd0_addr (src1_arf_id),
        .o_rd0_data (w_rf_rd0),
        .i_rd1_addr (src2_arf_id),
        .o_rd1_data (w_rf_rd1)
    );

    // Dispatch is ordered after the retire clear so a same-cycle new mapping wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ARF; i++)
                r_rat[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < N_ARF; i++)
                r_rat[i].busy <= 1'b0;
        end else begin
            if (w_ret_we && (r_rat[retire_arf_id].rob_id == retire_rob_id))
                r_rat[retire_arf_id].busy <= 1'b0;
            if (w_disp_we) begin
                r_rat[dispatch_dst_arf_id].busy   <= 1'b1;
                r_rat[dispatch_dst_arf_id].rob_id <= dispatch_rob_id;
            end
        end
    end

    always_comb begin
        w_src1 = resolve_src(src1_arf_id, r_rat[src1_arf_id], w_rf_rd0,
                             retire, retire_arf_id, retire_rob_id, retire_reg_data);
        w_src2 = resolve_src(src2_arf_id, r_rat[src2_arf_id], w_rf_rd1,
                             retire, retire_arf_id, retire_rob_id, retire_reg_data);
    end

    assign src1_renamed  = w_src1.renamed;
    assign src1_rob_id   = w_src1.rob_id;
    assign src1_reg_data = w_src1.data;
    assign src2_renamed  = w_src2.renamed;
    assign src2_rob_id   = w_src2.rob_id;
    assign src2_reg_data = w_src2.data;

endmodule

// File: tb/tb_arf_rat.sv
// tb/tb_arf_rat.sv - self-checking bench for arf_rat against a register-level reference model
module tb_arf_rat;

    logic        clk = 1'b0;
    logic        rst;
    logic        dispatch_fire;
    logic [3:0]  dispatch_rob_id;
    logic        dispatch_dst_valid;
    logic [4:0]  dispatch_dst_arf_id;
    logic [4:0]  src1_arf_id;
    logic [4:0]  src2_arf_id;
    logic        src1_renamed;
    logic [3:0]  src1_rob_id;
    logic [31:0] src1_reg_data;
    logic        src2_renamed;
    logic [3:0]  src2_rob_id;
    logic [31:0] src2_reg_data;
    logic        retire;
    logic [3:0]  retire_rob_id;
    logic [4:0]  retire_arf_id;
    logic [31:0] retire_reg_data;
    logic        flush;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    arf_rat dut (
        .clk                 (clk),
        .rst                 (rst),
        .dispatch_fire       (dispatch_fire),
        .dispatch_rob_id     (dispatch_rob_id),
        .dispatch_dst_valid  (dispatch_dst_valid),
        .dispatch_dst_arf_id (dispatch_dst_arf_id),
        .src1_arf_id         (src1_arf_id),
        .src2_arf_id         (src2_arf_id),
        .src1_renamed        (src1_renamed),
        .src1_rob_id         (src1_rob_id),
        .src1_reg_data       (src1_reg_data),
        .src2_renamed        (src2_renamed),
        .src2_rob_id         (src2_rob_id),
        .src2_reg_data       (src2_reg_data),
        .retire              (retire),
        .retire_rob_id       (retire_rob_id),
        .retire_arf_id       (retire_arf_id),
        .retire_reg_data     (retire_reg_data),
        .flush               (flush)
    );

    // Reference model: committed values and the youngest in-flight producer per register.
    logic [31:0] m_data [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    typedef struct packed {
        logic        ren;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t e1, e2;

    function automatic exp_t exp_src(input logic [4:0] id);
        exp_t e;
        e = '0;
        if (id == 5'd0) return e;
        if (retire && retire_arf_id == id && m_busy[id] && m_tag[id] == retire_rob_id) begin
            e.data = retire_reg_data;
            return e;
        end
        e.ren  = m_busy[id];
        e.tag  = m_tag[id];
        e.data = m_data[id];
        return e;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = '0;
                m_busy[i] = 0;
                m_tag[i]  = '0;
            end
        end else begin
            if (retire && retire_arf_id != 0) m_data[retire_arf_id] = retire_reg_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else begin
                if (retire && retire_arf_id != 0 && m_tag[retire_arf_id] == retire_rob_id)
                    m_busy[retire_arf_id] = 0;
                if (dispatch_fire && dispatch_dst_valid && dispatch_dst_arf_id != 0) begin
                    m_busy[dispatch_dst_arf_id] = 1;
                    m_tag[dispatch_dst_arf_id]  = dispatch_rob_id;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; dispatch_fire = 0; dispatch_rob_id = '0; dispatch_dst_valid = 0;
        dispatch_dst_arf_id = '0; retire = 0; retire_rob_id = '0; retire_arf_id = '0;
        retire_reg_data = '0; flush = 0;
    endtask

    task automatic dispatch(input logic [4:0] dst, input logic [3:0] rob);
        dispatch_fire = 1; dispatch_dst_valid = 1; dispatch_dst_arf_id = dst; dispatch_rob_id = rob;
    endtask

    task automatic do_retire(input logic [4:0] arf, input logic [3:0] rob, input logic [31:0] d);
        retire = 1; retire_arf_id = arf; retire_rob_id = rob; retire_reg_data = d;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); idle();
        src1_arf_id = 5; src2_arf_id = 6; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_rob_id !== 4'd0 || src1_reg_data !== 32'd0)
            $display("FAIL reset_src1: got ren=%0b tag=%0d data=%h want 0/0/0", src1_renamed, src1_rob_id, src1_reg_data);
        else n_pass++;
        n_total++;
        if (src2_renamed !== 1'b0 || src2_rob_id !== 4'd0 || src2_reg_data !== 32'd0)
            $display("FAIL reset_src2: got ren=%0b tag=%0d data=%h want 0/0/0", src2_renamed, src2_rob_id, src2_reg_data);
        else n_pass++;
    endtask

    task automatic test_retire_unmapped();
        idle(); do_retire(5, 3, 32'hDEADBEEF); src1_arf_id = 5; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_reg_data !== 32'd0)
            $display("FAIL retire_unmapped_same: got ren=%0b data=%h want 0/00000000", src1_renamed, src1_reg_data);
        else n_pass++;
        tick(); idle(); src1_arf_id = 5; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_reg_data !== 32'hDEADBEEF)
            $display("FAIL retire_unmapped_next: got ren=%0b data=%h want 0/deadbeef", src1_renamed, src1_reg_data);
        else n_pass++;
    endtask

    task automatic test_dispatch_own_dst();
        idle(); dispatch(7, 2); src1_arf_id = 7; #4;
        n_total++;
        if (src1_renamed !== 1'b0)
            $display("FAIL dispatch_sees_old: got ren=%0b want 0", src1_renamed);
        else n_pass++;
        tick(); idle(); src1_arf_id = 7; #4;
        n_total++;
        if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd2)
            $display("FAIL dispatch_mapped: got ren=%0b tag=%0d want 1/2", src1_renamed, src1_rob_id);
        else n_pass++;
    endtask

    task automatic test_younger_producer();
        idle(); dispatch(7, 5); tick();
        idle(); do_retire(7, 2, 32'h11); src1_arf_id = 7; #4;
        n_total++;
        if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd5)
            $display("FAIL younger_no_bypass: got ren=%0b tag=%0d want 1/5", src1_renamed, src1_rob_id);
        else n_pass++;
        tick(); idle(); src1_arf_id = 7; #4;
        n_total++;
        if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd5)
            $display("FAIL younger_keeps_map: got ren=%0b tag=%0d want 1/5", src1_renamed, src1_rob_id);
        else n_pass++;
        flush = 1; tick(); idle(); src1_arf_id = 7; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_reg_data !== 32'h11)
            $display("FAIL younger_data_written: got ren=%0b data=%h want 0/00000011", src1_renamed, src1_reg_data);
        else n_pass++;
    endtask

    task automatic test_retire_bypass();
        idle(); dispatch(9, 4); tick();
        idle(); do_retire(9, 4, 32'hABCD); src2_arf_id = 9; #4;
        n_total++;
        if (src2_renamed !== 1'b0 || src2_reg_data !== 32'hABCD)
            $display("FAIL bypass_same_cycle: got ren=%0b data=%h want 0/0000abcd", src2_renamed, src2_reg_data);
        else n_pass++;
        tick(); idle(); src2_arf_id = 9; #4;
        n_total++;
        if (src2_renamed !== 1'b0 || src2_reg_data !== 32'hABCD)
            $display("FAIL bypass_next: got ren=%0b data=%h want 0/0000abcd", src2_renamed, src2_reg_data);
        else n_pass++;
    endtask

    task automatic test_flush();
        idle(); dispatch(1, 1); tick();
        idle(); dispatch(2, 2); tick();
        idle(); flush = 1; dispatch(3, 3); src1_arf_id = 1; src2_arf_id = 2; #4;
        n_total++;
        if (src1_renamed !== 1'b1 || src1_rob_id !== 4'd1 || src2_renamed !== 1'b1 || src2_rob_id !== 4'd2)
            $display("FAIL flush_reads_pre: got %0b/%0d %0b/%0d want 1/1 1/2", src1_renamed, src1_rob_id, src2_renamed, src2_rob_id);
        else n_pass++;
        tick(); idle(); src1_arf_id = 1; src2_arf_id = 2; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src2_renamed !== 1'b0)
            $display("FAIL flush_clears: got ren1=%0b ren2=%0b want 0/0", src1_renamed, src2_renamed);
        else n_pass++;
        src1_arf_id = 3; #1;
        n_total++;
        if (src1_renamed !== 1'b0)
            $display("FAIL flush_drops_dispatch: got ren=%0b want 0", src1_renamed);
        else n_pass++;
    endtask

    task automatic test_x0();
        idle(); dispatch(0, 6); do_retire(0, 6, 32'hFF); src1_arf_id = 0; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_reg_data !== 32'd0)
            $display("FAIL x0_same: got ren=%0b data=%h want 0/0", src1_renamed, src1_reg_data);
        else n_pass++;
        tick(); idle(); src1_arf_id = 0; src2_arf_id = 0; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_reg_data !== 32'd0 || src2_renamed !== 1'b0 || src2_reg_data !== 32'd0)
            $display("FAIL x0_next: got %0b/%h %0b/%h want 0/0", src1_renamed, src1_reg_data, src2_renamed, src2_reg_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 99) < 60) begin
                dispatch_fire = 1;
                dispatch_dst_valid = ($urandom_range(0, 9) != 0);
                dispatch_dst_arf_id = 5'($urandom_range(0, 7));
                dispatch_rob_id = 4'($urandom);
            end
            if ($urandom_range(0, 99) < 55) begin
                a = 5'($urandom_range(0, 7));
                retire = 1; retire_arf_id = a; retire_reg_data = $urandom;
                retire_rob_id = ($urandom_range(0, 1) != 0) ? m_tag[a] : 4'($urandom);
            end
            flush = ($urandom_range(0, 99) < 5);
            src1_arf_id = 5'($urandom_range(0, 8));
            src2_arf_id = ($urandom_range(0, 3) == 0) ? retire_arf_id : 5'($urandom_range(0, 8));
            #4;
            e1 = exp_src(src1_arf_id);
            e2 = exp_src(src2_arf_id);
            n_total++;
            if (src1_renamed !== e1.ren || (e1.ren ? (src1_rob_id !== e1.tag) : (src1_reg_data !== e1.data)))
                $display("FAIL rand_src1 n=%0d x%0d: got %0b/%0d/%h want %0b/%0d/%h", n, src1_arf_id,
                         src1_renamed, src1_rob_id, src1_reg_data, e1.ren, e1.tag, e1.data);
            else n_pass++;
            n_total++;
            if (src2_renamed !== e2.ren || (e2.ren ? (src2_rob_id !== e2.tag) : (src2_reg_data !== e2.data)))
                $display("FAIL rand_src2 n=%0d x%0d: got %0b/%0d/%h want %0b/%0d/%h", n, src2_arf_id,
                         src2_renamed, src2_rob_id, src2_reg_data, e2.ren, e2.tag, e2.data);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        idle(); do_retire(10, 0, 32'h55); tick();
        idle(); dispatch(4, 7); tick();
        idle(); rst = 1; dispatch(5, 8); do_retire(6, 1, 32'h66); tick();
        idle(); src1_arf_id = 4; src2_arf_id = 5; #4;
        n_total++;
        if (src1_renamed !== 1'b0 || src1_rob_id !== 4'd0 || src2_renamed !== 1'b0 || src2_rob_id !== 4'd0)
            $display("FAIL midreset_rat: got %0b/%0d %0b/%0d want 0/0 0/0", src1_renamed, src1_rob_id, src2_renamed, src2_rob_id);
        else n_pass++;
        src1_arf_id = 10; src2_arf_id = 6; #1;
        n_total++;
        if (src1_reg_data !== 32'd0 || src2_reg_data !== 32'd0)
            $display("FAIL midreset_data: got %h %h want 0 0", src1_reg_data, src2_reg_data);
        else n_pass++;
    endtask

    initial begin
        idle(); src1_arf_id = '0; src2_arf_id = '0;
        test_reset();
        test_retire_unmapped();
        test_dispatch_own_dst();
        test_younger_producer();
        test_retire_bypass();
        test_flush();
        test_x0();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arf_rat.md
Name: arf_rat

Overview:
- Architectural register file plus register alias table (RAT), sitting at dispatch/register-read, directly upstream of the ROB.
- At dispatch it renames each instruction's destination to its ROB id and resolves both sources to committed ARF data or an in-flight ROB id.
- It consumes the ROB retire stream to commit results and to clear mappings.
- It consumes the ROB redirect to drop all speculative mappings.

Parameters:
- N_ARF, 32, number of architectural registers (x0 hardwired zero).
- ROB_N_ENTRIES, 16, ROB depth; the ROB id width is log2(ROB_N_ENTRIES) = 4.
- REG_DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dispatch_fire  in  1  dispatch handshake completed this cycle (valid & ready across ififo/ROB/IIQ/LSQ).
- dispatch_rob_id  in  4  ROB id allocated to the dispatching instruction.
- dispatch_dst_valid  in  1  instruction writes a destination register.
- dispatch_dst_arf_id  in  5  destination architectural register.
- src1_arf_id  in  5  source 1 architectural register.
- src2_arf_id  in  5  source 2 architectural register.
- src1_renamed  out  1  source 1 is produced by an in-flight ROB entry.
- src1_rob_id  out  4  producing ROB id; meaningful only when src1_renamed=1.
- src1_reg_data  out  32  committed value; meaningful only when src1_renamed=0.
- src2_renamed, src2_rob_id, src2_reg_data  out  1/4/32  same as source 1, for source 2.
- retire  in  1  ROB head writes the ARF this cycle.
- retire_rob_id  in  4  ROB id of the retiring entry.
- retire_arf_id  in  5  destination register of the retiring entry.
- retire_reg_data  in  32  value being committed.
- flush  in  1  ROB retire redirect (branch mispredict at head).

Behaviour:
- State:
  - ARF data[N_ARF] (32b each).
  - RAT entries, each {busy (1b), rob_id (4b)}.
- Reset: when rst=1 at a clock edge, all data=0, busy=0, rob_id=0. Outputs after reset: src*_renamed=0, src*_rob_id=0, src*_reg_data=0.
- Reset mid-operation discards everything, including a same-cycle dispatch or retire.
- Source read is combinational (0-cycle latency) and returns the state before this cycle's dispatch write, so an instruction never sees its own destination.
- If arf_id=0: renamed=0, data=0, always.
- Retire bypass: if retire=1, retire_arf_id=src_arf_id, and the RAT entry is busy with rob_id=retire_rob_id, then the source reports renamed=0 and data=retire_reg_data. This prevents a stale wait on a tag that is leaving the ROB.
- Otherwise the source reports renamed=busy, rob_id=RAT rob_id, data=ARF data.
- Dispatch write, on dispatch_fire & dispatch_dst_valid & dst≠0 at the clock edge:
  - RAT[dst].busy ← 1.
  - RAT[dst].rob_id ← dispatch_rob_id.
- Retire write, on retire & retire_arf_id≠0:
  - data[arf] ← retire_reg_data.
  - Clear busy only if RAT[arf].rob_id = retire_rob_id (a younger producer keeps the mapping).
- Dispatch and retire to the same register in the same cycle: data is written; the dispatch mapping wins (busy=1, new rob_id).
- Flush: at the edge, all busy ← 0; rob_id contents are don't-care.
  - A same-cycle retire still writes data. The ROB does not retire a mispredicted head, so this case is legal but benign.
  - A same-cycle dispatch_fire is ignored by the RAT (the instruction is flushed).
- Reads during a flush cycle return pre-flush state.
- Writes to x0 are dropped in all cases.
- No internal state machine beyond the per-entry busy/tag registers. No backpressure: always ready.

Decomposition:
- Shared global package: arf_id_t (5b), rob_id_t (4b), reg_data_t (32b), rat_entry_t {busy, rob_id}, N_ARF, ROB_N_ENTRIES, REG_DATA_WIDTH.
- Sub-module arf_regfile: 32×32, 1 write and 2 read ports, x0 reads zero, synchronous write with rst clear.
- The RAT busy/tag array and the bypass muxes live in arf_rat.

Test Plan:
1. Reset, then read x5/x6 → renamed=0, data=0. Retire arf=5 data=0xDEADBEEF rob=3 with no mapping → next cycle src1=x5 gives data 0xDEADBEEF, renamed=0.
2. Dispatch dst=x7 rob=2 while reading src1=x7 same cycle → renamed=0 (old state). Next cycle → renamed=1, rob_id=2.
3. Map x7→rob2, then map x7→rob5, then retire rob2 arf7 data=0x11 → busy stays 1, rob_id=5, data[x7]=0x11.
4. x9 mapped to rob4; in the cycle of retire rob4 arf9 data=0xABCD, read src2=x9 → renamed=0, data=0xABCD. Next cycle busy=0.
5. Map x1→rob1, x2→rob2; assert flush together with dispatch dst=x3 rob=3 → next cycle x1, x2, x3 all renamed=0.
6. Dispatch dst=x0 rob=6 and retire arf=0 data=0xFF → src1=x0 returns renamed=0, data=0 forever. Assert rst mid-stream with mappings present → all state cleared next cycle.
